// File: rtl/echo_detector.sv
// echo_detector: finds the first confirmed echo after an ultrasonic emission.
// Samples are ignored while the transmitter rings down (BLANK). The block then
// waits for a run of CONFIRM_COUNT consecutive above-threshold samples, follows
// the echo peak until the signal drops back to the release level, and reports
// the arrival time and peak amplitude. A no-echo result is reported if the
// timeout is reached first.
// Optional build macro: ECHO_DETECTOR_HYSTERESIS_EN lowers the release level to
// THRESHOLD-HYSTERESIS (saturating at 0). Without it the release level is
// THRESHOLD and HYSTERESIS has no effect.
// DATA_WIDTH and TIME_WIDTH are expected to be 32 or less.

module echo_detector #(
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned TIME_WIDTH     = 24,
    parameter int unsigned THRESHOLD      = 5000,
    parameter int unsigned HYSTERESIS     = 1000,
    parameter int unsigned CONFIRM_COUNT  = 4,
    parameter int unsigned BLANK_CYCLES   = 65536,
    parameter int unsigned TIMEOUT_CYCLES = 16000000
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  burst_start_in,
    input  logic [DATA_WIDTH-1:0] sample_in,
    input  logic                  sample_valid_in,
    input  logic [TIME_WIDTH-1:0] time_in,
    output logic                  echo_detected_out,
    output logic [TIME_WIDTH-1:0] echo_time_out,
    output logic [DATA_WIDTH-1:0] peak_out,
    output logic                  valid_out,
    output logic                  no_echo_out
);

`ifdef ECHO_DETECTOR_HYSTERESIS_EN
    localparam bit HYST_EN = 1'b1;
`else
    localparam bit HYST_EN = 1'b0;
`endif

    // Hysteresis release level saturates at zero instead of wrapping.
    localparam int unsigned HYST_LEVEL =
        (THRESHOLD > HYSTERESIS) ? (THRESHOLD - HYSTERESIS) : 0;
    localparam int unsigned RELEASE_LEVEL = HYST_EN ? HYST_LEVEL : THRESHOLD;

    // Run counter only needs to reach CONFIRM_COUNT.
    localparam int CW = (CONFIRM_COUNT > 1) ? $clog2(CONFIRM_COUNT + 1) : 1;

    typedef enum logic [2:0] {
        BLANK,
        SEARCH,
        CONFIRM,
        TRACK,
        DONE
    } state_t;

    state_t          state;
    logic [CW-1:0]   run_count;

    logic [31:0]           sample_ext;
    logic [31:0]           time_ext;
    logic                  above;
    logic                  released;
    logic                  blank_over;
    logic                  timed_out;
    logic                  confirm_hit;
    logic [DATA_WIDTH-1:0] new_peak;

    // Unsigned decode of the current sample and time against the fixed levels.
    always_comb begin
        sample_ext  = 32'(sample_in);
        time_ext    = 32'(time_in);
        above       = sample_ext > THRESHOLD;
        released    = sample_ext <= RELEASE_LEVEL;
        blank_over  = time_ext >= BLANK_CYCLES;
        timed_out   = time_ext >= TIMEOUT_CYCLES;
        confirm_hit = (32'(run_count) + 32'd1) >= CONFIRM_COUNT;
        new_peak    = (sample_in > peak_out) ? sample_in : peak_out;
    end

    // Detection FSM; every output is a register updated here.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state             <= BLANK;
            run_count         <= '0;
            echo_detected_out <= 1'b0;
            echo_time_out     <= '0;
            peak_out          <= '0;
            valid_out         <= 1'b0;
            no_echo_out       <= 1'b0;
        end else if (burst_start_in) begin
            state             <= BLANK;
            run_count         <= '0;
            echo_detected_out <= 1'b0;
            echo_time_out     <= '0;
            peak_out          <= '0;
            valid_out         <= 1'b0;
            no_echo_out       <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            case (state)
                BLANK: begin
                    if (blank_over) begin
                        state <= SEARCH;
                    end
                end
                SEARCH: begin
                    if (timed_out) begin
                        state         <= DONE;
                        no_echo_out   <= 1'b1;
                        valid_out     <= 1'b1;
                        echo_time_out <= '0;
                        peak_out      <= '0;
                        run_count     <= '0;
                    end else if (sample_valid_in && above) begin
                        echo_time_out <= time_in;
                        peak_out      <= sample_in;
                        run_count     <= CW'(1);
                        if (CONFIRM_COUNT <= 1) begin
                            state             <= TRACK;
                            echo_detected_out <= 1'b1;
                        end else begin
                            state <= CONFIRM;
                        end
                    end
                end
                CONFIRM: begin
                    if (timed_out) begin
                        state         <= DONE;
                        no_echo_out   <= 1'b1;
                        valid_out     <= 1'b1;
                        echo_time_out <= '0;
                        peak_out      <= '0;
                        run_count     <= '0;
                    end else if (sample_valid_in) begin
                        if (above) begin
                            run_count <= run_count + 1'b1;
                            peak_out  <= new_peak;
                            if (confirm_hit) begin
                                state             <= TRACK;
                                echo_detected_out <= 1'b1;
                            end
                        end else begin
                            state     <= SEARCH;
                            run_count <= '0;
                            peak_out  <= '0;
                        end
                    end
                end
                TRACK: begin
                    if (timed_out) begin
                        state     <= DONE;
                        valid_out <= 1'b1;
                    end else if (sample_valid_in) begin
                        peak_out <= new_peak;
                        if (released) begin
                            state     <= DONE;
                            valid_out <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state     <= BLANK;
                    run_count <= '0;
                end
            endcase
        end
    end

endmodule
